// File: rtl/l4_output_reader.sv
// l4_output_reader: streams the pooled L4 feature maps out of two BRAM banks
// to the L5 stage through a credit-limited pair FIFO and a 2-beat serializer.
module l4_output_reader #(
    parameter int DATA_WIDTH   = 12,
    parameter int BANK_DEPTH   = 200,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L5_en,
    output logic [7:0]            L4_output_read_addr,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data1,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data2,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8:0]            out_index,
    output logic                  out_last,
    output logic                  L5_load_done
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
    localparam logic [7:0]    LAST_ADDR = 8'(BANK_DEPTH - 1);
    localparam logic [8:0]    LAST_IDX  = 9'(2 * BANK_DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                  st;
    logic [7:0]              addr;
    logic [READ_LATENCY-1:0] vld;
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [NW-1:0]           count;
    logic                    beat;
    logic [8:0]              idx;
    logic [CW-1:0]           inflight;
    logic [2*DATA_WIDTH-1:0] head;
    logic                    abort;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    hs;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Reads still in the BRAM pipeline, used for the credit check.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + CW'(vld[i]);
    end

    assign abort = (st != IDLE) && !L5_en;
    assign issue = (st == STREAM) && !abort &&
                   ((inflight + CW'(count)) < CW'(FIFO_DEPTH));
    assign push  = vld[READ_LATENCY-1] && !abort;
    assign head  = mem[rd_ptr];

    assign out_valid = (count != '0);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && beat;
    assign out_data  = !out_valid ? '0 :
                       beat ? head[DATA_WIDTH-1:0] :
                              head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_index = idx;
    assign out_last  = out_valid && (idx == LAST_IDX);

    assign L4_output_read_addr = addr;
    assign L5_load_done        = (st == DONE);

    // Pair storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {L4_output_read_data1, L4_output_read_data2};
    end

    // FSM, read issue, inflight pipe, FIFO pointers and serializer.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            st     <= IDLE;
            addr   <= '0;
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= 1'b0;
            idx    <= '0;
        end else begin
            vld <= (vld << 1) | READ_LATENCY'(issue);
            if (issue && addr != LAST_ADDR)
                addr <= addr + 1'b1;
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (hs) begin
                beat <= !beat;
                idx  <= idx + 1'b1;
            end
            unique case (st)
                IDLE:    if (L5_en) st <= STREAM;
                STREAM:  if (issue && addr == LAST_ADDR) st <= DRAIN;
                DRAIN:   if (vld == '0 && count == '0) st <= DONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l4_output_reader.sv
// tb_l4_output_reader: scoreboard bench for l4_output_reader with a
// 2-cycle BRAM model and directed stall/abort/reset scenarios.
module tb_l4_output_reader;
    localparam int DW = 12;
    localparam int BD = 200;
    localparam int NB = 400;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [8:0]    idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          L5_en;
    logic [7:0]    addr;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_index;
    logic          out_last;
    logic          done;

    logic [DW-1:0] bank1 [BD];
    logic [DW-1:0] bank2 [BD];
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;

    exp_t          exp_q[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    int            acc = 0;
    int            rmode = 0;
    int            stall_n = 0;
    logic [15:0]   lfsr;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] pd;
    logic [8:0]    pi;

    always #5 clk = ~clk;

    l4_output_reader dut (
        .clk                  (clk),
        .rst                  (rst),
        .L5_en                (L5_en),
        .L4_output_read_addr  (addr),
        .L4_output_read_data1 (d1),
        .L4_output_read_data2 (d2),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_index            (out_index),
        .out_last             (out_last),
        .L5_load_done         (done)
    );

    initial begin
        for (int a = 0; a < BD; a++) begin
            bank1[a] = DW'(a);
            bank2[a] = DW'(12'h800 + a);
        end
    end

    // Two-stage BRAM read pipeline.
    always @(posedge clk) begin
        r1 <= bank1[addr];
        r2 <= bank2[addr];
        d1 <= r1;
        d2 <= r2;
    end

    // Consumer readiness generator.
    initial begin
        lfsr = 16'hACE1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: begin
                    out_ready = 1'b1;
                    stall_n = 0;
                end
                1: begin
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    out_ready = lfsr[0];
                end
                default: begin
                    if (out_valid && stall_n < 20) begin
                        out_ready = 1'b0;
                        stall_n++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops expectations on each handshake, checks hold and range.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected index %0d data=%h", out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_index !== e.idx || out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                                 out_data, out_index, out_last, e.data, e.idx, e.last);
                    end
                end
                acc++;
            end
            if (rst && prev_stall && out_valid) begin
                checks++;
                if (out_data !== pd || out_index !== pi) begin
                    errors++;
                    $display("FAIL hold: got data=%h idx=%0d, want data=%h idx=%0d",
                             out_data, out_index, pd, pi);
                end
            end
            checks++;
            if (addr > 8'(BD - 1)) begin
                errors++;
                $display("FAIL addr_range: got %0d, want <= %0d", addr, BD - 1);
            end
            prev_stall = rst && out_valid && !out_ready;
            pd = out_data;
            pi = out_index;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic chk_le(input string name, input int got, input int lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s: got %0d, want <= %0d", name, got, lim);
        end
    endtask

    task automatic push_run();
        exp_t x;
        for (int k = 0; k < NB; k++) begin
            x.data = (k % 2 == 0) ? DW'(k / 2) : DW'(12'h800 + (k - 1) / 2);
            x.idx  = 9'(k);
            x.last = (k == NB - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_data"}, int'(out_data), 0);
        chk({tag, "_index"}, int'(out_index), 0);
        chk({tag, "_last"}, int'(out_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_addr"}, int'(addr), 0);
    endtask

    task automatic wait_done(input int budget, output int dc);
        int c = 0;
        while (c < budget && !done) begin
            cyc();
            c++;
        end
        dc = c;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no L5_load_done in %0d cycles, want done", budget);
        end
    endtask

    task automatic start_and_wait(input int budget, output int dc, output int fc);
        int c = 0;
        fc = -1;
        L5_en = 1'b1;
        while (c < budget && !done) begin
            cyc();
            c++;
            if (fc < 0 && out_valid)
                fc = c - 1;
        end
        dc = c - 1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no L5_load_done in %0d cycles, want done", budget);
        end
    endtask

    task automatic wait_beats(input int base, input int n, input int budget);
        int c = 0;
        while (acc - base < n && c < budget) begin
            cyc();
            c++;
        end
        chk_le("wait_beats_short", n - (acc - base), 0);
    endtask

    initial begin
        int a0;
        int dc1;
        int dc2;
        int fc;
        int c;
        rst = 1'b0;
        L5_en = 1'b0;
        repeat (3) cyc();
        chk_outputs_reset("reset");
        rst = 1'b1;
        repeat (2) cyc();
        chk("idle_valid", int'(out_valid), 0);

        // Full stream with out_ready held high.
        a0 = acc;
        push_run();
        start_and_wait(2000, dc1, fc);
        chk("full_first_valid_cycle", fc, 3);
        chk_le("full_done_cycle", dc1, 408);
        chk("full_beats", acc - a0, NB);
        chk("full_queue_left", exp_q.size(), 0);
        repeat (5) cyc();
        chk("done_hold", int'(done), 1);

        // Back-to-back: drop in DONE, rise one cycle later.
        L5_en = 1'b0;
        cyc();
        chk("b2b_done_falls", int'(done), 0);
        chk("b2b_addr_idle", int'(addr), 0);
        a0 = acc;
        push_run();
        start_and_wait(2000, dc2, fc);
        chk("b2b_same_latency", dc2, dc1);
        chk("b2b_first_valid_cycle", fc, 3);
        chk("b2b_beats", acc - a0, NB);
        chk("b2b_queue_left", exp_q.size(), 0);
        L5_en = 1'b0;
        cyc();

        // Consumer stalls 20 cycles at the first valid beat.
        rmode = 2;
        a0 = acc;
        push_run();
        L5_en = 1'b1;
        c = 0;
        while (stall_n < 20 && c < 200) begin
            cyc();
            c++;
        end
        chk("stall_reached", stall_n, 20);
        chk_le("stall_addr_outstanding", int'(addr), 4);
        chk("stall_no_beats", acc - a0, 0);
        chk("stall_valid_held", int'(out_valid), 1);
        wait_done(2000, dc2);
        chk("stall_beats", acc - a0, NB);
        chk("stall_queue_left", exp_q.size(), 0);
        L5_en = 1'b0;
        rmode = 0;
        cyc();

        // Random backpressure.
        rmode = 1;
        a0 = acc;
        push_run();
        start_and_wait(4000, dc2, fc);
        chk("rand_beats", acc - a0, NB);
        chk("rand_queue_left", exp_q.size(), 0);
        L5_en = 1'b0;
        rmode = 0;
        cyc();

        // Abort at beat 150, then restart from zero.
        a0 = acc;
        push_run();
        L5_en = 1'b1;
        wait_beats(a0, 150, 1000);
        L5_en = 1'b0;
        cyc();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_addr", int'(addr), 0);
        chk("abort_index", int'(out_index), 0);
        exp_q.delete();
        a0 = acc;
        push_run();
        start_and_wait(2000, dc2, fc);
        chk("restart_first_valid_cycle", fc, 3);
        chk("restart_beats", acc - a0, NB);
        chk("restart_queue_left", exp_q.size(), 0);
        L5_en = 1'b0;
        cyc();

        // Reset pulse at beat 75 with L5_en held high.
        a0 = acc;
        push_run();
        L5_en = 1'b1;
        wait_beats(a0, 75, 1000);
        rst = 1'b0;
        cyc();
        chk_outputs_reset("midreset");
        rst = 1'b1;
        exp_q.delete();
        a0 = acc;
        push_run();
        wait_done(2000, dc2);
        chk("midreset_beats", acc - a0, NB);
        chk("midreset_queue_left", exp_q.size(), 0);
        L5_en = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
